qei_ctrl: RTL
=============

QEI_CTRL -- requirements
Module: qei_ctrl

Interface
REQ-001 The block SHALL have parameter BIT_WIDTH, default 8, setting the width of the position counter and the delta register.
REQ-002 The block SHALL have parameter FILT_LEN, default 4, setting the number of consecutive identical samples needed to accept an encoder state (range 1..15).
REQ-003 Port clk, input, 1 bit: the single system clock; all state is on its rising edge.
REQ-004 Port nrst, input, 1 bit: asynchronous active-low reset.
REQ-005 Port enc_a, input, 1 bit: encoder phase A, asynchronous to clk.
REQ-006 Port enc_b, input, 1 bit: encoder phase B, asynchronous to clk.
REQ-007 Port clr, input, 1 bit: synchronous clear of pos, delta accumulator and err.
REQ-008 Port rd_req, input, 1 bit: level request from the CPU to read and consume the accumulated delta.
REQ-009 Port rd_ack, output, 1 bit: one-cycle pulse meaning rd_data is valid.
REQ-010 Port rd_data, output, BIT_WIDTH bits: signed two's-complement delta snapshot.
REQ-011 Port pos, output, BIT_WIDTH bits: absolute position counter that wraps modulo 2^BIT_WIDTH.
REQ-012 Port dir, output, 1 bit: direction of the last counted step, 1 = up and 0 = down.
REQ-013 Port err, output, 1 bit: sticky flag for an illegal two-step transition.

Function
REQ-014 enc_a and enc_b SHALL each pass through a 2-flop synchronizer before any other use.
REQ-015 The filter SHALL accept the synchronized pair {b,a} as the new state only after FILT_LEN consecutive identical samples; any change restarts the run counter.
REQ-016 Accepted states SHALL be mapped to phase index 00->0, 01->1, 11->2 and 10->3.
REQ-017 On each accepted state that differs from the previous one, step = (new - prev) mod 4; both prev and the new state are phase indices.
 - step 1: count +1, dir=1.
 - step 3: count -1, dir=0.
 - step 2: set err, no count change, dir unchanged.
REQ-018 The first accepted state after reset or clr SHALL only load prev (primed flag); it SHALL NOT count and SHALL NOT set err.
REQ-019 pos SHALL update one cycle after acceptance and SHALL wrap: 2^W-1 +1 -> 0, and 0 -1 -> 2^W-1.
REQ-020 The delta accumulator SHALL be signed BIT_WIDTH bits and SHALL saturate at +2^(W-1)-1 and -2^(W-1), with no wrap; pos still counts while delta is saturated.
REQ-021 The read FSM SHALL have states IDLE, ACK and WAIT_LOW.
 - IDLE: rd_req=1 -> ACK. In that cycle rd_data <= accumulator + the same-cycle step (saturated), and the accumulator is cleared to 0.
 - ACK: rd_ack=1 for exactly one cycle -> WAIT_LOW.
 - WAIT_LOW: stays until rd_req=0 -> IDLE. Steps keep accumulating in this state.
REQ-022 Each rd_req assertion SHALL yield exactly one rd_ack; rd_req held high SHALL NOT cause repeated reads.
REQ-023 rd_data SHALL hold its value until the next snapshot.
REQ-024 A step arriving in the snapshot cycle SHALL be counted exactly once, in rd_data and not in the accumulator.
REQ-025 clr SHALL take priority over a same-cycle step and SHALL zero pos, the accumulator and err, and clear primed.
 - clr SHALL NOT alter rd_data or the FSM state.
 - clr in the snapshot cycle makes rd_data 0.
REQ-026 err SHALL clear only on clr or reset.

Reset
REQ-027 While nrst=0, all of the following SHALL hold:
 - pos=0, rd_data=0, rd_ack=0, dir=0, err=0;
 - accumulator=0, synchronizers=0, filter run counter=0;
 - primed=0, FSM=IDLE.
REQ-028 Reset SHALL act asynchronously at assertion; deassertion mid-handshake SHALL return to IDLE with no rd_ack issued.

Verification
REQ-029 Reset, then sequence 00,01,11,10,00 with each state held 8 cycles, W=8 -> pos=4, dir=1, err=0 (first 00 only primes).
REQ-030 pos=0 with one reverse step 00->10 -> pos=8'hFF, dir=0; then rd_req -> rd_ack pulse with rd_data=8'hFF and accumulator=0.
REQ-031 Glitch on enc_a lasting 2 cycles with FILT_LEN=4 -> no change to pos or err; jump 00->11 held -> err=1 and pos unchanged.
REQ-032 200 forward steps with no read, W=8 -> pos=200 (8'hC8) and rd_data after a read = 8'h7F (saturated).
REQ-033 rd_req held high for 20 cycles while 3 steps occur after the ack -> exactly one rd_ack; the next read returns 3.
REQ-034 clr asserted in the same cycle as rd_req and a step -> rd_data=0, pos=0, err=0, and the next accepted state only primes.

Source files
------------

// File: rtl/qei_ctrl_if.sv
// CPU read handshake for the quadrature encoder interface: a level request
// answered by a one-cycle acknowledge that qualifies the delta snapshot.
interface qei_ctrl_if #(
    parameter int BIT_WIDTH = 8
) ();
    logic                 rd_req;
    logic                 rd_ack;
    logic [BIT_WIDTH-1:0] rd_data;

    modport master (
        output rd_req,
        input  rd_ack,
        input  rd_data
    );

    modport slave (
        input  rd_req,
        output rd_ack,
        output rd_data
    );
endinterface

// File: rtl/qei_ctrl.sv
// qei_ctrl: quadrature encoder decoder. Synchronizes and debounces the A/B
// phases, keeps a wrapping absolute position, a sticky illegal-step flag and
// a saturating signed delta that the CPU reads and consumes via a handshake.
module qei_ctrl #(
    parameter int BIT_WIDTH = 8,
    parameter int FILT_LEN  = 4
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 enc_a,
    input  logic                 enc_b,
    input  logic                 clr,
    qei_ctrl_if.slave            rd_bus,
    output logic [BIT_WIDTH-1:0] pos,
    output logic                 dir,
    output logic                 err
);
    localparam logic [3:0] FILT_N = 4'(FILT_LEN);
    localparam logic signed [BIT_WIDTH-1:0] SAT_MAX = {1'b0, {(BIT_WIDTH-1){1'b1}}};
    localparam logic signed [BIT_WIDTH-1:0] SAT_MIN = {1'b1, {(BIT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACK, WAIT_LOW} rd_state_t;

    // Gray state {b,a} to phase index: 00->0, 01->1, 11->2, 10->3.
    function automatic logic [1:0] phase_of(input logic [1:0] ba);
        return {ba[1], ba[1] ^ ba[0]};
    endfunction

    // Signed add of a unit step that clamps instead of wrapping.
    function automatic logic signed [BIT_WIDTH-1:0] sat_add(
        input logic signed [BIT_WIDTH-1:0] a,
        input logic signed [1:0]           d
    );
        logic signed [BIT_WIDTH:0] s;
        s = {a[BIT_WIDTH-1], a} + {{(BIT_WIDTH-1){d[1]}}, d};
        if (s[BIT_WIDTH] != s[BIT_WIDTH-1])
            return s[BIT_WIDTH] ? SAT_MIN : SAT_MAX;
        return s[BIT_WIDTH-1:0];
    endfunction

    logic [1:0]                  enc_p0, enc_p1;
    logic [1:0]                  cand;
    logic [3:0]                  run;
    logic                        vld_p2;
    logic [1:0]                  phase_p2;
    logic [1:0]                  prev;
    logic                        primed;
    logic [1:0]                  step;
    logic                        up, dn, bad;
    logic signed [1:0]           dstep;
    logic signed [BIT_WIDTH-1:0] accum, accum_next, rd_data_q;
    logic                        rd_ack_q;
    rd_state_t                   state;

    // Stage p0/p1: two-flop synchronizer on the raw phases, packed as {b,a}.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            enc_p0 <= 2'b00;
            enc_p1 <= 2'b00;
        end else begin
            enc_p0 <= {enc_b, enc_a};
            enc_p1 <= enc_p0;
        end
    end

    // Stage p2: debounce; a state is accepted once, when its run reaches FILT_LEN.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cand     <= 2'b00;
            run      <= 4'd0;
            vld_p2   <= 1'b0;
            phase_p2 <= 2'd0;
        end else if (enc_p1 != cand) begin
            cand     <= enc_p1;
            run      <= 4'd1;
            vld_p2   <= (FILT_N == 4'd1);
            phase_p2 <= phase_of(enc_p1);
        end else if (run < FILT_N) begin
            run      <= run + 4'd1;
            vld_p2   <= (run + 4'd1 == FILT_N);
            phase_p2 <= phase_of(enc_p1);
        end else begin
            vld_p2   <= 1'b0;
        end
    end

    // Classify the accepted state against the previous phase and form the delta step.
    always_comb begin
        step       = phase_p2 - prev;
        up         = vld_p2 && primed && (step == 2'd1);
        dn         = vld_p2 && primed && (step == 2'd3);
        bad        = vld_p2 && primed && (step == 2'd2);
        dstep      = up ? 2'sb01 : (dn ? 2'sb11 : 2'sb00);
        accum_next = sat_add(accum, dstep);
    end

    // Position, direction, sticky error and priming; clr wins over a same-cycle step.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pos    <= '0;
            dir    <= 1'b0;
            err    <= 1'b0;
            prev   <= 2'd0;
            primed <= 1'b0;
        end else if (clr) begin
            pos    <= '0;
            err    <= 1'b0;
            primed <= 1'b0;
        end else begin
            if (vld_p2) begin
                prev   <= phase_p2;
                primed <= 1'b1;
            end
            if (up) begin
                pos <= pos + BIT_WIDTH'(1);
                dir <= 1'b1;
            end
            if (dn) begin
                pos <= pos - BIT_WIDTH'(1);
                dir <= 1'b0;
            end
            if (bad)
                err <= 1'b1;
        end
    end

    // Read FSM: snapshot accumulator plus same-cycle step, ack once, wait for request to drop.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            rd_ack_q  <= 1'b0;
            rd_data_q <= '0;
            accum     <= '0;
        end else begin
            rd_ack_q <= 1'b0;
            accum    <= clr ? '0 : accum_next;
            case (state)
                IDLE: begin
                    if (rd_bus.rd_req) begin
                        state     <= ACK;
                        rd_ack_q  <= 1'b1;
                        rd_data_q <= clr ? '0 : accum_next;
                        accum     <= '0;
                    end
                end
                ACK: begin
                    state <= WAIT_LOW;
                end
                WAIT_LOW: begin
                    if (!rd_bus.rd_req)
                        state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign rd_bus.rd_ack  = rd_ack_q;
    assign rd_bus.rd_data = rd_data_q;
endmodule
